branch_resolver: RTL and testbench

- Decode-stage branch unit of the pipelined RAT CPU. Holds the architectural C/Z flags and their interrupt shadow copies.
- Resolves BRN/BREQ/BRNE/BRCS/BRCC/CALL/RET/RETI, selects the PC target and drives UNCON_BRN / TAKE_COND_BRN into the downstream NOP generator.
- Enforces a branch-shadow lockout so wrong-path branches already in flight cannot redirect the PC.

---
 rtl/branch_resolver.sv | 145 ++++++++++++++
 tb/tb_branch_resolver.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
//
// Decode-stage branch unit of the pipelined RAT CPU. It resolves
// BRN/BREQ/BRNE/BRCS/BRCC/CALL/RET/RETI in the same cycle the instruction sits
// in decode, and drives the PC redirect plus the UNCON_BRN / TAKE_COND_BRN
// hints to the downstream NOP generator. It owns the architectural C/Z flags
// and their interrupt shadow copies. After any redirect, a short lockout
// ignores the wrong-path branches that are already in flight.
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   BR_VALID        decode slot holds a live instruction
//   BR_TYPE[2:0]    0 none, 1 BRN, 2 BREQ, 3 BRNE, 4 BRCS, 5 BRCC, 6 CALL, 7 RET
//   IS_RETI         qualifies BR_TYPE=7 as RETI (restores shadow flags)
//   IMM_ADDR        target for types 1-6
//   RET_ADDR        stack-popped target for type 7
//   FLG_LD          EX-stage ALU writes flags this cycle
//   FLG_C_NEW/Z_NEW EX-stage flag results
//   INT_TAKEN       interrupt accepted this cycle
//   UNCON_BRN       unconditional redirect (BRN/CALL/RET/RETI)
//   TAKE_COND_BRN   conditional branch taken
//   PC_LD           load PC with PC_TARGET
//   PC_TARGET       redirect address (0 when PC_LD=0)
//   FLG_C/FLG_Z     architectural flags (registered)
//   SHADOW_BUSY     lockout counter non-zero
// ----------------------------------------------------------------------------
module branch_resolver #(
  parameter int ADDR_W        = 10,
  parameter int SHADOW_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BR_VALID,
  input  logic [2:0]        BR_TYPE,
  input  logic              IS_RETI,
  input  logic [ADDR_W-1:0] IMM_ADDR,
  input  logic [ADDR_W-1:0] RET_ADDR,
  input  logic              FLG_LD,
  input  logic              FLG_C_NEW,
  input  logic              FLG_Z_NEW,
  input  logic              INT_TAKEN,
  output logic              UNCON_BRN,
  output logic              TAKE_COND_BRN,
  output logic              PC_LD,
  output logic [ADDR_W-1:0] PC_TARGET,
  output logic              FLG_C,
  output logic              FLG_Z,
  output logic              SHADOW_BUSY
);

  localparam int CNT_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(SHADOW_CYCLES);

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_BRN  = 3'd1,
    BT_BREQ = 3'd2,
    BT_BRNE = 3'd3,
    BT_BRCS = 3'd4,
    BT_BRCC = 3'd5,
    BT_CALL = 3'd6,
    BT_RET  = 3'd7
  } br_type_e;

  br_type_e         br_type;
  logic [CNT_W-1:0] shadow_cnt;
  logic             shadow_c;
  logic             shadow_z;
  logic             eff_c;
  logic             eff_z;
  logic             req;
  logic             cond_met;
  logic             reti_accept;

  assign br_type = br_type_e'(BR_TYPE);

  // Forward the EX-stage flag result so a flag-setting instruction directly
  // ahead of a branch is evaluated without a stall.
  assign eff_c = FLG_LD ? FLG_C_NEW : FLG_C;
  assign eff_z = FLG_LD ? FLG_Z_NEW : FLG_Z;

  assign SHADOW_BUSY = (shadow_cnt != '0);
  assign req         = BR_VALID & (br_type != BT_NONE) & ~SHADOW_BUSY;
  assign reti_accept = req & (br_type == BT_RET) & IS_RETI;

  always_comb begin
    cond_met = 1'b0;
    unique case (br_type)
      BT_BREQ: cond_met = eff_z;
      BT_BRNE: cond_met = ~eff_z;
      BT_BRCS: cond_met = eff_c;
      BT_BRCC: cond_met = ~eff_c;
      default: cond_met = 1'b0;
    endcase
  end

  // PC_TARGET is forced to zero when no redirect happens, so downstream
  // logic never sees a stale address.
  always_comb begin
    UNCON_BRN     = req & ((br_type == BT_BRN) | (br_type == BT_CALL) | (br_type == BT_RET));
    TAKE_COND_BRN = req & cond_met;
    PC_LD         = UNCON_BRN | TAKE_COND_BRN;
    PC_TARGET     = '0;
    if (PC_LD) begin
      PC_TARGET = (br_type == BT_RET) ? RET_ADDR : IMM_ADDR;
    end
  end

  // Lockout counter. It reloads on every redirect and otherwise counts down
  // to zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_cnt <= '0;
    end else if (PC_LD) begin
      shadow_cnt <= SHADOW_LOAD;
    end else if (SHADOW_BUSY) begin
      shadow_cnt <= shadow_cnt - CNT_W'(1);
    end
  end

  // Flag registers. An interrupt saves the forwarded flags, so a coincident
  // FLG_LD result is preserved across the ISR. The interrupt also wins over
  // a RETI restore and over a plain flag load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FLG_C    <= 1'b0;
      FLG_Z    <= 1'b0;
      shadow_c <= 1'b0;
      shadow_z <= 1'b0;
    end else if (INT_TAKEN) begin
      shadow_c <= eff_c;
      shadow_z <= eff_z;
      FLG_C    <= 1'b0;
      FLG_Z    <= 1'b0;
    end else if (reti_accept) begin
      FLG_C <= shadow_c;
      FLG_Z <= shadow_z;
    end else if (FLG_LD) begin
      FLG_C <= FLG_C_NEW;
      FLG_Z <= FLG_Z_NEW;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// ----------------------------------------------------------------------------
// tb_branch_resolver
//
// Directed bench for branch_resolver. A cycle-numbered behavioural model
// tracks the flags, shadow flags and the cycle of the last redirect. Every
// falling edge compares all DUT outputs against that model. Hand-computed
// literal expectations from the test plan pin the model itself.
// ----------------------------------------------------------------------------
module tb_branch_resolver;

  localparam int ADDR_W        = 10;
  localparam int SHADOW_CYCLES = 3;

  logic              CLK;
  logic              RESET;
  logic              BR_VALID;
  logic [2:0]        BR_TYPE;
  logic              IS_RETI;
  logic [ADDR_W-1:0] IMM_ADDR;
  logic [ADDR_W-1:0] RET_ADDR;
  logic              FLG_LD;
  logic              FLG_C_NEW;
  logic              FLG_Z_NEW;
  logic              INT_TAKEN;
  logic              UNCON_BRN;
  logic              TAKE_COND_BRN;
  logic              PC_LD;
  logic [ADDR_W-1:0] PC_TARGET;
  logic              FLG_C;
  logic              FLG_Z;
  logic              SHADOW_BUSY;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  branch_resolver #(
    .ADDR_W       (ADDR_W),
    .SHADOW_CYCLES(SHADOW_CYCLES)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BR_VALID     (BR_VALID),
    .BR_TYPE      (BR_TYPE),
    .IS_RETI      (IS_RETI),
    .IMM_ADDR     (IMM_ADDR),
    .RET_ADDR     (RET_ADDR),
    .FLG_LD       (FLG_LD),
    .FLG_C_NEW    (FLG_C_NEW),
    .FLG_Z_NEW    (FLG_Z_NEW),
    .INT_TAKEN    (INT_TAKEN),
    .UNCON_BRN    (UNCON_BRN),
    .TAKE_COND_BRN(TAKE_COND_BRN),
    .PC_LD        (PC_LD),
    .PC_TARGET    (PC_TARGET),
    .FLG_C        (FLG_C),
    .FLG_Z        (FLG_Z),
    .SHADOW_BUSY  (SHADOW_BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: the lockout is the distance in cycles from the last
  // redirect, not a down-counter.
  int cyc           = 0;
  int last_redirect = -1000;
  bit m_c  = 0;
  bit m_z  = 0;
  bit m_sc = 0;
  bit m_sz = 0;

  bit                exp_busy;
  bit                exp_uncon;
  bit                exp_take;
  bit                exp_ld;
  logic [ADDR_W-1:0] exp_target;
  bit                exp_reti;
  bit                f_c;
  bit                f_z;

  always_comb begin
    f_c        = FLG_LD ? FLG_C_NEW : m_c;
    f_z        = FLG_LD ? FLG_Z_NEW : m_z;
    exp_busy   = (cyc - last_redirect >= 1) && (cyc - last_redirect <= SHADOW_CYCLES);
    exp_uncon  = 1'b0;
    exp_take   = 1'b0;
    exp_target = '0;
    if (BR_VALID && !exp_busy) begin
      case (BR_TYPE)
        3'd1, 3'd6, 3'd7: exp_uncon = 1'b1;
        3'd2:             exp_take  = f_z;
        3'd3:             exp_take  = !f_z;
        3'd4:             exp_take  = f_c;
        3'd5:             exp_take  = !f_c;
        default:          exp_take  = 1'b0;
      endcase
    end
    exp_ld   = exp_uncon || exp_take;
    exp_reti = exp_uncon && (BR_TYPE == 3'd7) && IS_RETI;
    if (exp_ld) exp_target = (BR_TYPE == 3'd7) ? RET_ADDR : IMM_ADDR;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) begin
      last_redirect <= -1000;
      m_c  <= 0;
      m_z  <= 0;
      m_sc <= 0;
      m_sz <= 0;
    end else begin
      if (exp_ld) last_redirect <= cyc;
      if (INT_TAKEN) begin
        m_sc <= f_c;
        m_sz <= f_z;
        m_c  <= 0;
        m_z  <= 0;
      end else if (exp_reti) begin
        m_c <= m_sc;
        m_z <= m_sz;
      end else if (FLG_LD) begin
        m_c <= FLG_C_NEW;
        m_z <= FLG_Z_NEW;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("cmp_uncon",  32'(UNCON_BRN),     32'(exp_uncon));
      checkOutput("cmp_take",   32'(TAKE_COND_BRN), 32'(exp_take));
      checkOutput("cmp_pc_ld",  32'(PC_LD),         32'(exp_ld));
      checkOutput("cmp_target", 32'(PC_TARGET),     32'(exp_target));
      checkOutput("cmp_flg_c",  32'(FLG_C),         32'(m_c));
      checkOutput("cmp_flg_z",  32'(FLG_Z),         32'(m_z));
      checkOutput("cmp_busy",   32'(SHADOW_BUSY),   32'(exp_busy));
    end
  end

  task automatic applyStimulus(input bit valid, input logic [2:0] btype,
                               input logic [ADDR_W-1:0] imm, input logic [ADDR_W-1:0] ret,
                               input bit reti, input bit fld, input bit cn, input bit zn,
                               input bit intk);
    BR_VALID  = valid;
    BR_TYPE   = btype;
    IMM_ADDR  = imm;
    RET_ADDR  = ret;
    IS_RETI   = reti;
    FLG_LD    = fld;
    FLG_C_NEW = cn;
    FLG_Z_NEW = zn;
    INT_TAKEN = intk;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    RESET = 1'b1;
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    tick();
    check_en = 1;
    tick();
    RESET = 1'b0;

    // Reset state
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("rst_flg_c", 32'(FLG_C), 32'd0);
    checkOutput("rst_flg_z", 32'(FLG_Z), 32'd0);
    checkOutput("rst_busy",  32'(SHADOW_BUSY), 32'd0);
    checkOutput("rst_pc_ld", 32'(PC_LD), 32'd0);
    tick();

    // BRN 0x2A5, then exactly three busy cycles
    applyStimulus(1, 3'd1, 10'h2A5, 10'h000, 0, 0, 0, 0, 0);
    checkOutput("brn_uncon",  32'(UNCON_BRN), 32'd1);
    checkOutput("brn_pc_ld",  32'(PC_LD), 32'd1);
    checkOutput("brn_target", 32'(PC_TARGET), 32'h2A5);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
      checkOutput("brn_busy", 32'(SHADOW_BUSY), 32'd1);
      tick();
    end
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("brn_busy_end", 32'(SHADOW_BUSY), 32'd0);
    tick();

    // BREQ with forwarded Z=1
    applyStimulus(1, 3'd2, 10'h111, 10'h000, 0, 1, 0, 1, 0);
    checkOutput("breq_fwd_take",   32'(TAKE_COND_BRN), 32'd1);
    checkOutput("breq_fwd_target", 32'(PC_TARGET), 32'h111);
    tick();
    idle(3);
    applyStimulus(0, 3'd0, '0, '0, 0, 1, 0, 0, 0);
    tick();
    // BRNE with forwarded Z=1 is not taken
    applyStimulus(1, 3'd3, 10'h222, 10'h000, 0, 1, 0, 1, 0);
    checkOutput("brne_fwd_pc_ld", 32'(PC_LD), 32'd0);
    checkOutput("brne_fwd_take",  32'(TAKE_COND_BRN), 32'd0);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("brne_busy",  32'(SHADOW_BUSY), 32'd0);
    checkOutput("brne_flg_z", 32'(FLG_Z), 32'd1);
    tick();

    // C=1, Z=0; BRN then BRCS ignored for three cycles, taken on the fourth
    applyStimulus(0, 3'd0, '0, '0, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 3'd1, 10'h010, 10'h000, 0, 0, 0, 0, 0);
    checkOutput("lock_brn_ld", 32'(PC_LD), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'd4, 10'h020, 10'h000, 0, 0, 0, 0, 0);
      checkOutput("lock_brcs_ignored", 32'(PC_LD), 32'd0);
      tick();
    end
    applyStimulus(1, 3'd4, 10'h020, 10'h000, 0, 0, 0, 0, 0);
    checkOutput("lock_brcs_take",   32'(TAKE_COND_BRN), 32'd1);
    checkOutput("lock_brcs_target", 32'(PC_TARGET), 32'h020);
    tick();
    idle(3);

    // Interrupt saves C=1/Z=0, RETI restores them
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("int_flg_c", 32'(FLG_C), 32'd0);
    checkOutput("int_flg_z", 32'(FLG_Z), 32'd0);
    tick();
    applyStimulus(1, 3'd7, 10'h123, 10'h0F0, 1, 0, 0, 0, 0);
    checkOutput("reti_uncon",  32'(UNCON_BRN), 32'd1);
    checkOutput("reti_target", 32'(PC_TARGET), 32'h0F0);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("reti_flg_c", 32'(FLG_C), 32'd1);
    checkOutput("reti_flg_z", 32'(FLG_Z), 32'd0);
    tick();
    idle(3);

    // Interrupt coincident with FLG_LD saves the forwarded 1/1
    applyStimulus(0, 3'd0, '0, '0, 0, 1, 1, 1, 1);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("intld_flg_c", 32'(FLG_C), 32'd0);
    checkOutput("intld_flg_z", 32'(FLG_Z), 32'd0);
    tick();
    applyStimulus(1, 3'd7, 10'h000, 10'h155, 1, 0, 0, 0, 0);
    checkOutput("reti2_uncon", 32'(UNCON_BRN), 32'd1);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("reti2_flg_c", 32'(FLG_C), 32'd1);
    checkOutput("reti2_flg_z", 32'(FLG_Z), 32'd1);
    tick();
    idle(3);

    // Plain RET (no IS_RETI) leaves the flags alone
    applyStimulus(0, 3'd0, '0, '0, 0, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 3'd7, 10'h000, 10'h0AA, 0, 0, 0, 0, 0);
    checkOutput("ret_target", 32'(PC_TARGET), 32'h0AA);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("ret_flg_c", 32'(FLG_C), 32'd0);
    tick();
    idle(3);

    // Interrupt coincident with a taken branch (BRCC, C=0)
    applyStimulus(1, 3'd5, 10'h1C0, 10'h000, 0, 0, 0, 0, 1);
    checkOutput("intbr_take", 32'(TAKE_COND_BRN), 32'd1);
    tick();
    idle(3);

    // Reset in the middle of a lockout
    applyStimulus(1, 3'd1, 10'h044, 10'h000, 0, 1, 1, 0, 0);
    checkOutput("rstmid_brn_ld", 32'(PC_LD), 32'd1);
    tick();
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_busy_pre", 32'(SHADOW_BUSY), 32'd1);
    checkOutput("rstmid_flg_c_pre", 32'(FLG_C), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    applyStimulus(0, 3'd0, '0, '0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_busy",  32'(SHADOW_BUSY), 32'd0);
    checkOutput("rstmid_flg_c", 32'(FLG_C), 32'd0);
    tick();
    applyStimulus(1, 3'd6, 10'h3FF, 10'h000, 0, 0, 0, 0, 0);
    checkOutput("call_uncon",  32'(UNCON_BRN), 32'd1);
    checkOutput("call_target", 32'(PC_TARGET), 32'h3FF);
    tick();
    idle(4);

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
